// File: rtl/gather_bytes_if.sv
// Narrow-in / wide-out stream bundle between the byte-wise compute stage,
// the packer and the PCIe TX FWFT FIFO.
interface gather_bytes_if #(
    parameter int C_IN_BYTES  = 1,
    parameter int C_OUT_BYTES = 4
);
    localparam int C_IN_WIDTH     = 8 * C_IN_BYTES;
    localparam int C_OUT_WIDTH    = 8 * C_OUT_BYTES;
    localparam int C_MULTPL       = C_OUT_BYTES / C_IN_BYTES;
    localparam int C_MULTPL_WIDTH = (C_MULTPL > 1) ? $clog2(C_MULTPL) : 1;

    logic                      INDATA_EN;
    logic [C_IN_WIDTH-1:0]     INDATA;
    logic                      INDATA_RD_EN;
    logic                      FLUSH;
    logic                      FLUSHED;
    logic                      OUTDATA_WR_EN;
    logic [C_OUT_WIDTH-1:0]    OUTDATA;
    logic [C_MULTPL_WIDTH:0]   OUTDATA_LANES;
    logic                      OUTDATA_FULL;

    // Producer/consumer side: feeds narrow words and FIFO status
    modport master (
        output INDATA_EN, INDATA, FLUSH, OUTDATA_FULL,
        input  INDATA_RD_EN, FLUSHED, OUTDATA_WR_EN, OUTDATA, OUTDATA_LANES
    );

    // Packer side
    modport slave (
        input  INDATA_EN, INDATA, FLUSH, OUTDATA_FULL,
        output INDATA_RD_EN, FLUSHED, OUTDATA_WR_EN, OUTDATA, OUTDATA_LANES
    );
endinterface

// File: rtl/gather_bytes.sv
// Packs C_IN_BYTES-wide words into C_OUT_BYTES-wide words, little-endian lane
// order, with a one-deep output register in front of the TX FIFO. A FLUSH
// drains the input, pushes out a zero-padded partial word and pulses FLUSHED.
module gather_bytes #(
    parameter int C_IN_BYTES  = 1,
    parameter int C_OUT_BYTES = 4
) (
    input  logic            CLK,
    input  logic            RST,
    gather_bytes_if.slave   bus
);
    localparam int C_IN_WIDTH     = 8 * C_IN_BYTES;
    localparam int C_OUT_WIDTH    = 8 * C_OUT_BYTES;
    localparam int C_MULTPL       = C_OUT_BYTES / C_IN_BYTES;
    localparam int C_MULTPL_WIDTH = (C_MULTPL > 1) ? $clog2(C_MULTPL) : 1;

    localparam logic [C_MULTPL_WIDTH-1:0] LAST_POS  = C_MULTPL_WIDTH'(C_MULTPL - 1);
    localparam logic [C_MULTPL_WIDTH:0]   FULL_LANES = (C_MULTPL_WIDTH + 1)'(C_MULTPL);

    localparam logic [2:0] ST_RUN   = 3'd0;
    localparam logic [2:0] ST_DRAIN = 3'd1;
    localparam logic [2:0] ST_PAD   = 3'd2;
    localparam logic [2:0] ST_WAIT  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    logic [2:0]                                 state_q, state_d;
    logic [C_MULTPL_WIDTH-1:0]                  pos_q, pos_d;
    logic [C_MULTPL-1:0][C_IN_WIDTH-1:0]        acc_q, acc_d;
    logic                                       out_valid_q, out_valid_d;
    logic [C_OUT_WIDTH-1:0]                     out_data_q, out_data_d;
    logic [C_MULTPL_WIDTH:0]                    out_lanes_q, out_lanes_d;

    logic                                       rd_en;
    logic                                       wr_en;
    logic                                       out_free;
    logic                                       at_last;
    logic [C_MULTPL-1:0][C_IN_WIDTH-1:0]        pad_word;

    // Handshake terms: the output slot is free if empty or draining this cycle
    always_comb begin
        wr_en    = out_valid_q & ~bus.OUTDATA_FULL;
        out_free = ~out_valid_q | ~bus.OUTDATA_FULL;
        at_last  = (pos_q == LAST_POS);
        rd_en    = bus.INDATA_EN
                 & ((state_q == ST_RUN) | (state_q == ST_DRAIN))
                 & (~at_last | out_free);
    end

    // Partial word with lanes at and above the fill position forced to zero
    always_comb begin
        pad_word = '0;
        for (int i = 0; i < C_MULTPL; i++) begin
            if (C_MULTPL_WIDTH'(i) < pos_q) begin
                pad_word[i] = acc_q[i];
            end
        end
    end

    // Lane accumulation, output register load/drain and flush sequencing
    always_comb begin
        state_d     = state_q;
        pos_d       = pos_q;
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_lanes_d = out_lanes_q;

        // A load in the same cycle overrides this clear
        if (wr_en) begin
            out_valid_d = 1'b0;
        end

        if (rd_en) begin
            acc_d[pos_q] = bus.INDATA;
            if (at_last) begin
                out_data_d  = acc_d;
                out_lanes_d = FULL_LANES;
                out_valid_d = 1'b1;
                pos_d       = '0;
            end else begin
                pos_d = pos_q + C_MULTPL_WIDTH'(1);
            end
        end

        case (state_q)
            ST_RUN: begin
                if (bus.FLUSH) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!bus.INDATA_EN) begin
                    state_d = (pos_q != '0) ? ST_PAD : ST_WAIT;
                end
            end
            ST_PAD: begin
                if (out_free) begin
                    out_data_d  = pad_word;
                    out_lanes_d = {1'b0, pos_q};
                    out_valid_d = 1'b1;
                    pos_d       = '0;
                    state_d     = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!out_valid_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = bus.FLUSH ? ST_DRAIN : ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // State registers; reset discards partial and pending data
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= ST_RUN;
            pos_q       <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_lanes_q <= '0;
        end else begin
            state_q     <= state_d;
            pos_q       <= pos_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_lanes_q <= out_lanes_d;
        end
    end

    assign bus.INDATA_RD_EN  = rd_en;
    assign bus.OUTDATA_WR_EN = wr_en;
    assign bus.OUTDATA       = out_data_q;
    assign bus.OUTDATA_LANES = out_lanes_q;
    assign bus.FLUSHED       = (state_q == ST_DONE);

endmodule

// File: tb/tb_gather_bytes.sv
// Directed vector table plus hand-written reset and random-stream sequences
// for the gather_bytes packer (1-byte in, 4-byte out).
module tb_gather_bytes;
    logic clk = 1'b0;
    logic rst = 1'b1;

    gather_bytes_if #(.C_IN_BYTES(1), .C_OUT_BYTES(4)) bus ();

    gather_bytes #(.C_IN_BYTES(1), .C_OUT_BYTES(4)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        en;
        logic [7:0]  data;
        logic        flush;
        logic        full;
        logic        rd;
        logic        wr;
        logic [31:0] out;
        logic [2:0]  lanes;
        logic        flushed;
    } vec_t;

    vec_t vecs[$];

    logic        last_rd, last_wr, last_fl;
    logic [31:0] last_out;
    logic [2:0]  last_lanes;

    logic [7:0]  in_q[$];
    logic [31:0] wdata_q[$];
    logic [2:0]  wlanes_q[$];
    int          flushed_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic en, input logic [7:0] d, input logic fl, input logic fu,
                       input logic rd, input logic wr, input logic [31:0] o,
                       input logic [2:0] ln, input logic fd);
        vec_t v;
        v.en = en; v.data = d; v.flush = fl; v.full = fu;
        v.rd = rd; v.wr = wr; v.out = o; v.lanes = ln; v.flushed = fd;
        vecs.push_back(v);
    endtask

    // Drive one cycle of inputs, let outputs settle, and record transfers
    task automatic cycle(input logic en, input logic [7:0] d, input logic fl, input logic fu);
        @(negedge clk);
        bus.INDATA_EN    = en;
        bus.INDATA       = d;
        bus.FLUSH        = fl;
        bus.OUTDATA_FULL = fu;
        #1;
        last_rd    = bus.INDATA_RD_EN;
        last_wr    = bus.OUTDATA_WR_EN;
        last_fl    = bus.FLUSHED;
        last_out   = bus.OUTDATA;
        last_lanes = bus.OUTDATA_LANES;
        if (last_rd) in_q.push_back(d);
        if (last_wr) begin
            wdata_q.push_back(last_out);
            wlanes_q.push_back(last_lanes);
        end
        if (last_fl) flushed_cnt++;
    endtask

    task automatic clear_sb();
        in_q.delete();
        wdata_q.delete();
        wlanes_q.delete();
        flushed_cnt = 0;
    endtask

    initial begin
        logic [7:0] stream[1000];
        int idx;
        int got;
        int bad;
        int budget;
        int k;

        bus.INDATA_EN    = 1'b0;
        bus.INDATA       = '0;
        bus.FLUSH        = 1'b0;
        bus.OUTDATA_FULL = 1'b0;
        flushed_cnt      = 0;

        // en   data  flush full | rd wr out          lanes flushed
        add(0, 8'h00, 0, 0,   0, 0, 32'h00000000, 3'd0, 0);
        // full word, write one cycle after the last byte
        add(1, 8'h11, 0, 0,   1, 0, 32'h00000000, 3'd0, 0);
        add(1, 8'h22, 0, 0,   1, 0, 32'h00000000, 3'd0, 0);
        add(1, 8'h33, 0, 0,   1, 0, 32'h00000000, 3'd0, 0);
        add(1, 8'h44, 0, 0,   1, 0, 32'h00000000, 3'd0, 0);
        add(0, 8'h00, 0, 0,   0, 1, 32'h44332211, 3'd4, 0);
        add(0, 8'h00, 0, 0,   0, 0, 32'h44332211, 3'd4, 0);
        // partial word and flush
        add(1, 8'hAA, 0, 0,   1, 0, 32'h44332211, 3'd4, 0);
        add(1, 8'hBB, 0, 0,   1, 0, 32'h44332211, 3'd4, 0);
        add(0, 8'h00, 1, 0,   0, 0, 32'h44332211, 3'd4, 0);
        add(0, 8'h00, 0, 0,   0, 0, 32'h44332211, 3'd4, 0);
        add(0, 8'h00, 0, 0,   0, 0, 32'h44332211, 3'd4, 0);
        add(0, 8'h00, 0, 0,   0, 1, 32'h0000BBAA, 3'd2, 0);
        add(0, 8'h00, 0, 0,   0, 0, 32'h0000BBAA, 3'd2, 0);
        add(0, 8'h00, 0, 0,   0, 0, 32'h0000BBAA, 3'd2, 1);
        add(0, 8'h00, 0, 0,   0, 0, 32'h0000BBAA, 3'd2, 0);
        // empty flush at T: FLUSHED only at T+3
        add(0, 8'h00, 1, 0,   0, 0, 32'h0000BBAA, 3'd2, 0);
        add(0, 8'h00, 0, 0,   0, 0, 32'h0000BBAA, 3'd2, 0);
        add(0, 8'h00, 0, 0,   0, 0, 32'h0000BBAA, 3'd2, 0);
        add(0, 8'h00, 0, 0,   0, 0, 32'h0000BBAA, 3'd2, 1);
        add(0, 8'h00, 0, 0,   0, 0, 32'h0000BBAA, 3'd2, 0);
        // FIFO full: absorb 3 extra bytes then stall
        add(1, 8'h01, 0, 1,   1, 0, 32'h0000BBAA, 3'd2, 0);
        add(1, 8'h02, 0, 1,   1, 0, 32'h0000BBAA, 3'd2, 0);
        add(1, 8'h03, 0, 1,   1, 0, 32'h0000BBAA, 3'd2, 0);
        add(1, 8'h04, 0, 1,   1, 0, 32'h0000BBAA, 3'd2, 0);
        add(1, 8'h05, 0, 1,   1, 0, 32'h04030201, 3'd4, 0);
        add(1, 8'h06, 0, 1,   1, 0, 32'h04030201, 3'd4, 0);
        add(1, 8'h07, 0, 1,   1, 0, 32'h04030201, 3'd4, 0);
        add(1, 8'h08, 0, 1,   0, 0, 32'h04030201, 3'd4, 0);
        add(1, 8'h08, 0, 1,   0, 0, 32'h04030201, 3'd4, 0);
        add(1, 8'h08, 0, 0,   1, 1, 32'h04030201, 3'd4, 0);
        add(0, 8'h00, 0, 0,   0, 1, 32'h08070605, 3'd4, 0);
        add(0, 8'h00, 0, 0,   0, 0, 32'h08070605, 3'd4, 0);

        repeat (2) @(negedge clk);
        #1;
        check("reset_outdata", bus.OUTDATA, 32'h0);
        check("reset_lanes", {29'd0, bus.OUTDATA_LANES}, 32'h0);
        check("reset_wr_en", {31'd0, bus.OUTDATA_WR_EN}, 32'h0);
        check("reset_flushed", {31'd0, bus.FLUSHED}, 32'h0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            cycle(vecs[i].en, vecs[i].data, vecs[i].flush, vecs[i].full);
            check($sformatf("v%0d_rd_en", i), {31'd0, last_rd}, {31'd0, vecs[i].rd});
            check($sformatf("v%0d_wr_en", i), {31'd0, last_wr}, {31'd0, vecs[i].wr});
            check($sformatf("v%0d_outdata", i), last_out, vecs[i].out);
            check($sformatf("v%0d_lanes", i), {29'd0, last_lanes}, {29'd0, vecs[i].lanes});
            check($sformatf("v%0d_flushed", i), {31'd0, last_fl}, {31'd0, vecs[i].flushed});
        end

        // Mid-operation reset: one word pending behind FULL, two bytes partial
        clear_sb();
        cycle(1, 8'hA1, 0, 1);
        cycle(1, 8'hA2, 0, 1);
        cycle(1, 8'hA3, 0, 1);
        cycle(1, 8'hA4, 0, 1);
        cycle(1, 8'hB1, 0, 1);
        cycle(1, 8'hB2, 0, 1);
        check("pre_rst_pending", last_out, 32'hA4A3A2A1);
        @(negedge clk);
        bus.INDATA_EN    = 1'b0;
        bus.OUTDATA_FULL = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("rst_outdata", bus.OUTDATA, 32'h0);
        check("rst_lanes", {29'd0, bus.OUTDATA_LANES}, 32'h0);
        check("rst_wr_en", {31'd0, bus.OUTDATA_WR_EN}, 32'h0);
        check("rst_rd_en", {31'd0, bus.INDATA_RD_EN}, 32'h0);
        check("rst_flushed", {31'd0, bus.FLUSHED}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        clear_sb();
        cycle(0, 8'h00, 0, 0);
        cycle(1, 8'hC1, 0, 0);
        cycle(1, 8'hC2, 0, 0);
        cycle(1, 8'hC3, 0, 0);
        cycle(1, 8'hC4, 0, 0);
        cycle(0, 8'h00, 0, 0);
        cycle(0, 8'h00, 0, 0);
        check("post_rst_writes", wdata_q.size(), 1);
        if (wdata_q.size() > 0) begin
            check("post_rst_word", wdata_q[0], 32'hC4C3C2C1);
            check("post_rst_lanes", {29'd0, wlanes_q[0]}, 32'd4);
        end
        check("post_rst_flushed", flushed_cnt, 0);

        // Random stream with random backpressure, flushed at the end
        clear_sb();
        foreach (stream[i]) stream[i] = 8'($urandom);
        idx = 0;
        budget = 0;
        while (idx < 1000 && budget < 20000) begin
            cycle(($urandom_range(0, 3) != 0), stream[idx], 0, ($urandom_range(0, 2) == 0));
            if (last_rd) idx++;
            budget++;
        end
        check("rand_all_accepted", idx, 1000);
        cycle(0, 8'h00, 1, ($urandom_range(0, 2) == 0));
        budget = 0;
        while (flushed_cnt == 0 && budget < 200) begin
            cycle(0, 8'h00, 0, ($urandom_range(0, 2) == 0));
            budget++;
        end
        check("rand_flushed_seen", flushed_cnt, 1);
        k = wdata_q.size();
        repeat (5) cycle(0, 8'h00, 0, 0);
        check("rand_no_write_after_flushed", wdata_q.size(), k);
        check("rand_single_flushed", flushed_cnt, 1);

        got = 0;
        bad = 0;
        foreach (wdata_q[w]) begin
            for (int l = 0; l < 4; l++) begin
                if (l < int'(wlanes_q[w])) begin
                    if (got < 1000) begin
                        if (wdata_q[w][8*l +: 8] !== stream[got]) bad++;
                    end
                    got++;
                end
            end
        end
        check("rand_byte_count", got, 1000);
        check("rand_byte_errors", bad, 0);
        check("rand_input_log", in_q.size(), 1000);
        if (wlanes_q.size() > 0) begin
            check("rand_last_lanes", {29'd0, wlanes_q[wlanes_q.size()-1]}, 32'd4);
        end else begin
            check("rand_any_writes", 0, 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
